alu_result_writeback: RTL and testbench
=======================================

Name: alu_result_writeback

Overview:
- Downstream stage of the ALU.
- In the `ALU_RESULTS` state it captures the ALU result word, the high/remainder word, the command and the destination address.
- It then writes the low word, and optionally the high word, to the destination over the shared data bus, and pulses next_state so the sequencer can advance.
- It sits between the ALU outputs and the bus arbiter, alongside the operand-fetch stage.

Parameters:
- DATA_W, 32, data word width; equals `DATA_SIZE.
- ADDR_W, 32, bus address width.
- ACK_TIMEOUT, 255, enabled cycles to wait for bus_ack before abandoning a write; minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- clk_oe  in  1  phase enable; FSM, counters and registers advance only on edges with clk_oe=1
- state  in  `STATE_SIZE  sequencer state
- command  in  32  current instruction; cmd code is bits [31:28]
- dst_in  in  DATA_W  ALU low result (valid while state==`ALU_RESULTS)
- dst_h_in  in  DATA_W  ALU high result or remainder
- dst_addr_in  in  ADDR_W  destination address for the low word
- bus_busy  in  1  another master owns the bus
- bus_ack  in  1  target accepted the current write
- bus_addr  out  ADDR_W  write address
- bus_data  out  DATA_W  write data
- bus_write  out  1  write strobe; held until acknowledged
- wb_err  out  1  sticky: a write timed out
- next_state  out  1  one enabled-cycle pulse: writeback complete

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. On reset:
  - FSM goes to IDLE; armed=1.
  - bus_addr=0, bus_data=0, bus_write=0, wb_err=0, next_state=0.
  - Captured registers and the timeout counter are cleared.
  - rst takes effect on any edge, regardless of clk_oe.
  - Reset mid-write drops bus_write at that edge; no DONE pulse.
- clk_oe=0 edges:
  - next_state is forced to 0.
  - All other state holds.
- FSM states: IDLE, WAIT_BUS, WR_LO, WR_HI, DONE.
- IDLE:
  - If state==`ALU_RESULTS and armed: capture dst_in, dst_h_in, dst_addr_in, command[31:28]; clear armed; go to WAIT_BUS.
  - armed is set again whenever state!=`ALU_RESULTS. This makes it one writeback per ALU_RESULTS visit, however long the state is held.
- WAIT_BUS:
  - If !bus_busy: drive bus_addr=addr, bus_data=lo, bus_write=1; clear the timeout counter; go to WR_LO.
  - Otherwise wait indefinitely (no timeout while bus_busy).
- WR_LO:
  - bus_write, bus_addr and bus_data are held stable.
  - bus_ack=1: deassert bus_write. Then go to WR_HI if the high write is required (see Optional Feature); otherwise go to DONE.
  - No ack: increment the counter. When the counter reaches ACK_TIMEOUT, set wb_err, deassert bus_write and go to DONE.
- WR_HI:
  - Entry drives bus_addr=addr+1 (modulo 2^ADDR_W, so 0xFFFFFFFF wraps to 0), bus_data=hi, bus_write=1, with the counter cleared.
  - The bus is not re-arbitrated; ownership is retained from the low write.
  - Ack and timeout rules are the same as WR_LO; then go to DONE.
- DONE: next_state=1 for exactly one enabled edge; go to IDLE.
- Latency: minimum 3 enabled edges from capture to the next_state pulse (low write only, immediate ack); 4 with a high write.
- bus_ack while not in WR_LO/WR_HI is ignored.
- bus_busy rising during WR_LO/WR_HI is ignored.
- wb_err clears only on rst.

Optional Feature:
- Macro: ALU_WB_HI_WRITE_EN.
- Defined: a high write follows the low write for cmd codes `CMD_ADD (carry), `CMD_SUB (borrow), `CMD_MUL (upper product) and `CMD_DIV (remainder). Other codes write the low word only.
- Undefined: the WR_HI state and its logic are removed; every command performs only the low write; dst_h_in is unused.

Decomposition:
- Shared package/include holds:
  - FSM state encodings (WB_IDLE..WB_DONE, 3-bit), added to states.v-style defines.
  - A "cmd has high result" predicate macro over the cmd_codes.v codes.
  - The ACK_TIMEOUT default.
- One natural sub-module: wb_ack_timer. It is a loadable counter with clear, enable (clk_oe) and an expired flag, reusable by the operand-fetch stage.

Test Plan:
- Basic: ALU_RESULTS, CMD_OR, dst_in=0x0000_00F0, addr=0x100, bus idle, ack after 2 cycles -> one write (0x100, 0xF0); next_state pulses once, 5 enabled edges after capture.
- Feature on: CMD_MUL, dst=0x0000_0001, dst_h=0x0000_0002, addr=0xFFFF_FFFF -> writes (0xFFFF_FFFF, 1) then (0x0000_0000, 2); with the feature off, only the first write occurs.
- Arbitration: bus_busy=1 for 10 cycles after capture -> bus_write stays 0 throughout; the write starts on the first edge with bus_busy=0; wb_err=0.
- Timeout: ACK_TIMEOUT=4, bus_ack never asserted -> bus_write held for 4 enabled edges, then wb_err=1 and next_state pulses once.
- Phase/hold: clk_oe toggling every edge, state held at ALU_RESULTS for 20 cycles -> exactly one writeback and one next_state pulse; next_state=0 on every clk_oe=0 edge.
- Reset mid-op: rst during WR_LO -> bus_write=0 after that edge, no next_state pulse; the next ALU_RESULTS visit writes normally.

Source files
------------

// File: rtl/alu_result_writeback_pkg.sv
// Shared types and constants for the ALU result writeback stage.
// Sequencer codes, command codes, writeback FSM encoding, defaults.
package alu_result_writeback_pkg;

   localparam int DATA_SIZE       = 32;
   localparam int STATE_SIZE      = 4;
   localparam int ACK_TIMEOUT_DEF = 255;

   localparam logic [STATE_SIZE-1:0] ST_FETCH       = 4'd0;
   localparam logic [STATE_SIZE-1:0] ST_DECODE      = 4'd1;
   localparam logic [STATE_SIZE-1:0] ST_OPERANDS    = 4'd2;
   localparam logic [STATE_SIZE-1:0] ST_EXECUTE     = 4'd3;
   localparam logic [STATE_SIZE-1:0] ST_ALU_RESULTS = 4'd4;

   localparam logic [3:0] CMD_ADD = 4'h0;
   localparam logic [3:0] CMD_SUB = 4'h1;
   localparam logic [3:0] CMD_MUL = 4'h2;
   localparam logic [3:0] CMD_DIV = 4'h3;
   localparam logic [3:0] CMD_AND = 4'h4;
   localparam logic [3:0] CMD_OR  = 4'h5;
   localparam logic [3:0] CMD_XOR = 4'h6;
   localparam logic [3:0] CMD_NOT = 4'h7;

   typedef enum logic [2:0] {
      WB_IDLE     = 3'd0,
      WB_WAIT_BUS = 3'd1,
      WB_WR_LO    = 3'd2,
      WB_WR_HI    = 3'd3,
      WB_DONE     = 3'd4
   } wb_state_e;

   // Commands whose second result word (carry, borrow,
   // upper product, remainder) is worth storing.
   function automatic logic cmd_has_hi(input logic [3:0] c);
      logic r;
      r = 1'b0;
      unique case (c)
         CMD_ADD, CMD_SUB,
         CMD_MUL, CMD_DIV: r = 1'b1;
         default:          r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_result_writeback_if.sv
// Shared data bus write port: address, data, strobe, busy, ack.
// master drives addr/data/write; slave answers busy/ack.
interface alu_result_writeback_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_data;
   logic              bus_write;
   logic              bus_busy;
   logic              bus_ack;

   modport master (
      output bus_addr,
      output bus_data,
      output bus_write,
      input  bus_busy,
      input  bus_ack
   );

   modport slave (
      input  bus_addr,
      input  bus_data,
      input  bus_write,
      output bus_busy,
      output bus_ack
   );

endinterface

// File: rtl/alu_result_writeback_wb_ack_timer.sv
// wb_ack_timer: loadable up-counter with clear, enable and expiry.
// Ports: clk, rst, en, clr, load, load_val, inc -> count, expired.
module wb_ack_timer #(
   parameter int LIMIT = 255,
   parameter int CW    = $clog2(LIMIT + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          expired
);

   // Raised while the increment about to happen
   // brings the count to LIMIT.
   assign expired = (count == CW'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         if (clr)
            count <= '0;
         else if (load)
            count <= load_val;
         else if (inc)
            count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/alu_result_writeback.sv
// ALU result writeback: captures ALU results, writes them to the bus.
// Ports: clk, rst, clk_oe, state, command, dst_in, dst_h_in,
// dst_addr_in, bus (master), wb_err, next_state.
// Build option ALU_WB_HI_WRITE_EN adds the high-word write.
module alu_result_writeback
   import alu_result_writeback_pkg::*;
#(
   parameter int DATA_W      = DATA_SIZE,
   parameter int ADDR_W      = 32,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_oe,
   input  logic [STATE_SIZE-1:0] state,
   input  logic [31:0]           command,
   input  logic [DATA_W-1:0]     dst_in,
   input  logic [DATA_W-1:0]     dst_h_in,
   input  logic [ADDR_W-1:0]     dst_addr_in,
   alu_result_writeback_if.master bus,
   output logic                  wb_err,
   output logic                  next_state
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   wb_state_e         wb_st;
   logic              armed;
   logic [DATA_W-1:0] lo_r;
   logic [ADDR_W-1:0] addr_r;
   logic [3:0]        cmd_r;
`ifdef ALU_WB_HI_WRITE_EN
   logic [DATA_W-1:0] hi_r;
`endif

   logic          tmr_clr;
   logic          tmr_inc;
   logic          tmr_exp;
   logic [CW-1:0] tmr_count;
   logic          unused_bits;

`ifdef ALU_WB_HI_WRITE_EN
   assign unused_bits = ^{command[27:0], tmr_count};
`else
   assign unused_bits = ^{command[27:0], tmr_count, dst_h_in};
`endif

   always_comb begin
      tmr_clr = 1'b0;
      tmr_inc = 1'b0;
      unique case (wb_st)
         WB_WAIT_BUS: tmr_clr = !bus.bus_busy;
         WB_WR_LO: begin
            tmr_clr = bus.bus_ack;
            tmr_inc = !bus.bus_ack;
         end
`ifdef ALU_WB_HI_WRITE_EN
         WB_WR_HI: tmr_inc = !bus.bus_ack;
`endif
         default: ;
      endcase
   end

   wb_ack_timer #(
      .LIMIT (ACK_TIMEOUT),
      .CW    (CW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .en       (clk_oe),
      .clr      (tmr_clr),
      .load     (1'b0),
      .load_val ('0),
      .inc      (tmr_inc),
      .count    (tmr_count),
      .expired  (tmr_exp)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_st         <= WB_IDLE;
         armed         <= 1'b1;
         lo_r          <= '0;
         addr_r        <= '0;
         cmd_r         <= '0;
`ifdef ALU_WB_HI_WRITE_EN
         hi_r          <= '0;
`endif
         bus.bus_addr  <= '0;
         bus.bus_data  <= '0;
         bus.bus_write <= 1'b0;
         wb_err        <= 1'b0;
         next_state    <= 1'b0;
      end else if (!clk_oe) begin
         next_state <= 1'b0;
      end else begin
         next_state <= 1'b0;
         // Re-arm only once the sequencer leaves ALU_RESULTS,
         // so a held state yields a single writeback.
         if (state != ST_ALU_RESULTS)
            armed <= 1'b1;
         unique case (wb_st)
            WB_IDLE: begin
               if (state == ST_ALU_RESULTS && armed) begin
                  lo_r   <= dst_in;
                  addr_r <= dst_addr_in;
                  cmd_r  <= command[31:28];
`ifdef ALU_WB_HI_WRITE_EN
                  hi_r   <= dst_h_in;
`endif
                  armed  <= 1'b0;
                  wb_st  <= WB_WAIT_BUS;
               end
            end
            WB_WAIT_BUS: begin
               if (!bus.bus_busy) begin
                  bus.bus_addr  <= addr_r;
                  bus.bus_data  <= lo_r;
                  bus.bus_write <= 1'b1;
                  wb_st         <= WB_WR_LO;
               end
            end
            WB_WR_LO: begin
               if (bus.bus_ack) begin
`ifdef ALU_WB_HI_WRITE_EN
                  // Keep bus ownership: the high word goes
                  // straight out on the next address.
                  if (cmd_has_hi(cmd_r)) begin
                     bus.bus_addr  <= addr_r + ADDR_W'(1);
                     bus.bus_data  <= hi_r;
                     bus.bus_write <= 1'b1;
                     wb_st         <= WB_WR_HI;
                  end else begin
                     bus.bus_write <= 1'b0;
                     wb_st         <= WB_DONE;
                  end
`else
                  bus.bus_write <= 1'b0;
                  wb_st         <= WB_DONE;
`endif
               end else if (tmr_exp) begin
                  wb_err        <= 1'b1;
                  bus.bus_write <= 1'b0;
                  wb_st         <= WB_DONE;
               end
            end
`ifdef ALU_WB_HI_WRITE_EN
            WB_WR_HI: begin
               if (bus.bus_ack) begin
                  bus.bus_write <= 1'b0;
                  wb_st         <= WB_DONE;
               end else if (tmr_exp) begin
                  wb_err        <= 1'b1;
                  bus.bus_write <= 1'b0;
                  wb_st         <= WB_DONE;
               end
            end
`endif
            WB_DONE: begin
               next_state <= 1'b1;
               wb_st      <= WB_IDLE;
            end
            default: wb_st <= WB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Scoreboard bench for alu_result_writeback.
// Bus responder, write/done monitor, directed scenarios.
module tb_alu_result_writeback;
   import alu_result_writeback_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  clk_oe;
   logic [STATE_SIZE-1:0] state;
   logic [31:0]           command;
   logic [DW-1:0]         dst_in;
   logic [DW-1:0]         dst_h_in;
   logic [AW-1:0]         dst_addr_in;
   logic                  wb_err;
   logic                  next_state;

   alu_result_writeback_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

   alu_result_writeback #(
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .ACK_TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_oe      (clk_oe),
      .state       (state),
      .command     (command),
      .dst_in      (dst_in),
      .dst_h_in    (dst_h_in),
      .dst_addr_in (dst_addr_in),
      .bus         (bus_if),
      .wb_err      (wb_err),
      .next_state  (next_state)
   );

   wr_t  exp_wr[$];
   logic exp_done[$];
   int   checks = 0;
   int   errors = 0;
   int   ack_delay = 0;
   int   pulses = 0;
   int   wr_high = 0;
   logic oe_prev = 1'b1;

   initial forever #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic wr_t mk(input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      return w;
   endfunction

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [3:0]    cmd,
                        input logic [DW-1:0] lo,
                        input logic [DW-1:0] hi,
                        input logic [AW-1:0] a);
      command     = {cmd, 28'h0};
      dst_in      = lo;
      dst_h_in    = hi;
      dst_addr_in = a;
      state       = ST_ALU_RESULTS;
      tick();
      state       = ST_EXECUTE;
   endtask

   task automatic wait_done(input int budget, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < budget) begin
         tick();
         n++;
         seen = next_state;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout got none in %0d want pulse", n);
      end
   endtask

   // Bus target: ack after ack_delay cycles of bus_write,
   // held until taken on an enabled edge; negative = never.
   initial begin
      int   wait_cnt;
      logic acc;
      wait_cnt = 0;
      bus_if.bus_ack = 1'b0;
      forever begin
         @(negedge clk);
         acc = bus_if.bus_write && bus_if.bus_ack && clk_oe;
         @(posedge clk);
         #2;
         if (acc || !bus_if.bus_write || ack_delay < 0) begin
            bus_if.bus_ack = 1'b0;
            wait_cnt = 0;
         end else if (wait_cnt >= ack_delay) begin
            bus_if.bus_ack = 1'b1;
         end else begin
            bus_if.bus_ack = 1'b0;
            wait_cnt++;
         end
      end
   end

   // Monitor: accepted writes and done pulses against queues.
   initial begin
      wr_t  e;
      logic d;
      forever begin
         @(negedge clk);
         if (bus_if.bus_write)
            wr_high++;
         if (bus_if.bus_write && bus_if.bus_ack &&
             clk_oe && !rst) begin
            if (exp_wr.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write got %0h/%0h want none",
                        bus_if.bus_addr, bus_if.bus_data);
            end else begin
               e = exp_wr.pop_front();
               chk("wr_addr", 64'(bus_if.bus_addr), 64'(e.addr));
               chk("wr_data", 64'(bus_if.bus_data), 64'(e.data));
            end
         end
         if (!oe_prev)
            chk("ns_on_oe_low", 64'(next_state), 64'd0);
         if (next_state) begin
            pulses++;
            if (exp_done.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done got pulse want none");
            end else begin
               d = exp_done.pop_front();
               chk("done_wb_err", 64'(wb_err), 64'(d));
            end
         end
         oe_prev = clk_oe;
      end
   end

   initial begin
      int n;
      int p0;
      int h0;
      rst            = 1'b1;
      clk_oe         = 1'b1;
      state          = ST_FETCH;
      command        = '0;
      dst_in         = '0;
      dst_h_in       = '0;
      dst_addr_in    = '0;
      bus_if.bus_busy = 1'b0;
      tick();
      tick();
      chk("rst_write", 64'(bus_if.bus_write), 64'd0);
      chk("rst_addr", 64'(bus_if.bus_addr), 64'd0);
      chk("rst_data", 64'(bus_if.bus_data), 64'd0);
      chk("rst_err", 64'(wb_err), 64'd0);
      chk("rst_ns", 64'(next_state), 64'd0);
      rst = 1'b0;
      tick();

      // Low-only write, ack two cycles late.
      ack_delay = 2;
      exp_wr.push_back(mk(32'h100, 32'h0000_00F0));
      exp_done.push_back(1'b0);
      start(CMD_OR, 32'h0000_00F0, 32'h0, 32'h100);
      wait_done(20, n);
      chk("basic_latency", 64'(n), 64'd5);
      tick();

      // Multiply: high word at wrapped address when enabled.
      ack_delay = 0;
      exp_wr.push_back(mk(32'hFFFF_FFFF, 32'h1));
`ifdef ALU_WB_HI_WRITE_EN
      exp_wr.push_back(mk(32'h0000_0000, 32'h2));
`endif
      exp_done.push_back(1'b0);
      start(CMD_MUL, 32'h1, 32'h2, 32'hFFFF_FFFF);
      wait_done(20, n);
`ifdef ALU_WB_HI_WRITE_EN
      chk("mul_latency", 64'(n), 64'd5);
`else
      chk("mul_latency", 64'(n), 64'd3);
`endif
      tick();

      // Arbitration: busy bus holds off the write.
      bus_if.bus_busy = 1'b1;
      exp_wr.push_back(mk(32'h200, 32'hDEAD_BEEF));
      exp_done.push_back(1'b0);
      start(CMD_AND, 32'hDEAD_BEEF, 32'h0, 32'h200);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("arb_hold_write", 64'(bus_if.bus_write), 64'd0);
      end
      bus_if.bus_busy = 1'b0;
      tick();
      chk("arb_start", 64'(bus_if.bus_write), 64'd1);
      chk("arb_addr", 64'(bus_if.bus_addr), 64'h200);
      wait_done(20, n);
      chk("arb_latency", 64'(n), 64'd2);
      tick();

      // Phase enable toggling, state held for 20 cycles.
      ack_delay = 1;
      p0 = pulses;
      exp_wr.push_back(mk(32'h300, 32'h55));
      exp_done.push_back(1'b0);
      command     = {CMD_XOR, 28'h0};
      dst_in      = 32'h55;
      dst_addr_in = 32'h300;
      state       = ST_ALU_RESULTS;
      for (int i = 0; i < 40; i++) begin
         if (i == 20)
            state = ST_EXECUTE;
         clk_oe = (i % 2 == 0);
         tick();
      end
      clk_oe = 1'b1;
      tick();
      tick();
      chk("hold_pulses", 64'(pulses - p0), 64'd1);
      chk("hold_writes_left", 64'(exp_wr.size()), 64'd0);

      // Ack timeout.
      ack_delay = -1;
      h0 = wr_high;
      exp_done.push_back(1'b1);
      start(CMD_SUB, 32'h7, 32'h8, 32'h400);
      wait_done(30, n);
      chk("to_latency", 64'(n), 64'd6);
      chk("to_write_cycles", 64'(wr_high - h0), 64'd4);
      chk("to_err", 64'(wb_err), 64'd1);
      tick();
      tick();
      chk("to_err_sticky", 64'(wb_err), 64'd1);

      // Reset in the middle of the low write.
      p0 = pulses;
      start(CMD_OR, 32'h11, 32'h0, 32'h500);
      tick();
      chk("rst_pre_write", 64'(bus_if.bus_write), 64'd1);
      tick();
      rst    = 1'b1;
      clk_oe = 1'b0;
      tick();
      rst    = 1'b0;
      clk_oe = 1'b1;
      chk("mid_rst_write", 64'(bus_if.bus_write), 64'd0);
      chk("mid_rst_addr", 64'(bus_if.bus_addr), 64'd0);
      chk("mid_rst_err", 64'(wb_err), 64'd0);
      for (int i = 0; i < 12; i++)
         tick();
      chk("mid_rst_no_pulse", 64'(pulses - p0), 64'd0);

      ack_delay = 0;
      exp_wr.push_back(mk(32'h600, 32'h66));
      exp_done.push_back(1'b0);
      start(CMD_OR, 32'h66, 32'h0, 32'h600);
      wait_done(20, n);
      chk("post_rst_latency", 64'(n), 64'd3);
      tick();
      tick();
      tick();
      chk("final_writes_left", 64'(exp_wr.size()), 64'd0);
      chk("final_done_left", 64'(exp_done.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
